// File: rtl/cpu_pkg.sv
// Shared CPU constants: fetch address/instruction widths, reset PC, fetch queue depth.
// Latency: n/a (package only).
// Backpressure: n/a.
package cpu_pkg;

   localparam int          CPU_A_WIDTH      = 8;
   localparam int          CPU_D_WIDTH      = 32;
   localparam int unsigned CPU_RESET_PC     = 0;
   // Output queue depth. The fetch credit check and the skid FIFO are sized to this.
   localparam int          FETCH_FIFO_DEPTH = 2;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry in-order skid FIFO holding {pc, instr} between memory response and decode.
// Latency: a push is visible at the head on the cycle after it is written.
// Backpressure: none internal; the producer's credit check keeps pushes within capacity.
// Ports: clk/rst (sync active-high), i_flush drops all entries, i_push/i_dat write,
//        i_pop removes the head, o_dat is the head entry, o_count is occupancy 0..2.
module fetch_skid_fifo #(
   parameter int W = 40
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_flush,
   input  logic         i_push,
   input  logic [W-1:0] i_dat,
   input  logic         i_pop,
   output logic [W-1:0] o_dat,
   output logic [1:0]   o_count
);

   logic [W-1:0] r_e0;   // head
   logic [W-1:0] r_e1;   // second entry
   logic [1:0]   r_cnt;
   logic         w_pop;
   logic         w_push;

   // Popping an empty queue is ignored; a push into a full queue is accepted only
   // together with a pop.
   assign w_pop  = i_pop && (r_cnt != 2'd0);
   assign w_push = i_push && ((r_cnt != 2'd2) || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 2'd0;
         r_e0  <= '0;
         r_e1  <= '0;
      end else if (i_flush) begin
         r_cnt <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_cnt == 2'd0) r_e0 <= i_dat;
               else               r_e1 <= i_dat;
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_e0  <= r_e1;
               r_cnt <= r_cnt - 2'd1;
            end
            2'b11: begin
               // Count is unchanged; the new word lands behind whatever remains.
               if (r_cnt == 2'd1) begin
                  r_e0 <= i_dat;
               end else begin
                  r_e0 <= r_e1;
                  r_e1 <= i_dat;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_dat   = r_e0;
   assign o_count = r_cnt;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, issues one word-address per cycle to a 1-cycle memory.
// Latency: issue in cycle N, data captured N+1, presented to decode N+2.
// Backpressure: decode valid/ready; issue is credit-limited so at most 2 words queue up.
// Ports: clk/rst (sync active-high); redirect_valid/redirect_pc load a new PC and flush;
//        mem_addr/mem_data talk to instruction memory; instr_valid/instr_ready/instr/instr_pc
//        form the decode handshake.
module ifu_fetch
   import cpu_pkg::*;
#(
   parameter int          A_WIDTH  = CPU_A_WIDTH,
   parameter int          D_WIDTH  = CPU_D_WIDTH,
   parameter int unsigned RESET_PC = CPU_RESET_PC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [A_WIDTH-1:0] redirect_pc,
   output logic [A_WIDTH-1:0] mem_addr,
   input  logic [D_WIDTH-1:0] mem_data,
   output logic               instr_valid,
   input  logic               instr_ready,
   output logic [D_WIDTH-1:0] instr,
   output logic [A_WIDTH-1:0] instr_pc
);

   logic [A_WIDTH-1:0]         r_pc;
   logic                       r_inflight;
   logic [A_WIDTH-1:0]         r_inflight_pc;

   logic [1:0]                 w_cnt;
   logic                       w_pop;
   logic                       w_issue;
   logic [2:0]                 w_occ;
   logic [A_WIDTH+D_WIDTH-1:0] w_head;

   assign mem_addr    = r_pc;
   assign instr_valid = (w_cnt != 2'd0);
   assign w_pop       = instr_valid && instr_ready;

   // Credit: queued words plus the one in flight, less the one leaving this cycle,
   // must stay below the queue depth so the response always has a slot next cycle.
   assign w_occ   = {1'b0, w_cnt} + {2'b00, r_inflight};
   assign w_issue = !rst && !redirect_valid &&
                    (w_occ < (3'(FETCH_FIFO_DEPTH) + {2'b00, w_pop}));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= A_WIDTH'(RESET_PC);
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (redirect_valid) begin
         // The response for any outstanding request is dropped by clearing the flag.
         r_pc       <= redirect_pc;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 1'b1;
         end
      end
   end

   // Flush takes priority over the push of an in-flight response inside the FIFO.
   fetch_skid_fifo #(
      .W (A_WIDTH + D_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect_valid),
      .i_push  (r_inflight),
      .i_dat   ({r_inflight_pc, mem_data}),
      .i_pop   (w_pop),
      .o_dat   (w_head),
      .o_count (w_cnt)
   );

   assign instr_pc = w_head[A_WIDTH+D_WIDTH-1:D_WIDTH];
   assign instr    = w_head[D_WIDTH-1:0];

endmodule
